// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The execute stage drives the master side; muldiv_unit implements the slave side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, in_op, in_src1, in_src2, flush,
    input  in_ready, busy, done, hi, lo
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, flush,
    output in_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / restoring radix-2 divide unit with architectural HI/LO,
// valid/ready request handshake and flush cancellation.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_MULU = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  state_t           state_next;

  logic             accept;
  logic             is_signed_op;
  logic             is_div_op;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]     mul_a;
  logic [WIDTH:0]     mul_b;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_dsr;
  logic [WIDTH-1:0] div_src1;
  logic             div_neg_q;
  logic             div_neg_r;
  logic             div_zero;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign accept       = bus.in_valid && (state == IDLE) && !bus.flush;
  assign is_signed_op = (bus.in_op == OP_MUL) || (bus.in_op == OP_DIV);
  assign is_div_op    = (bus.in_op == OP_DIV) || (bus.in_op == OP_DIVU);
  assign src1_mag     = (is_signed_op && bus.in_src1[WIDTH-1]) ? -bus.in_src1 : bus.in_src1;
  assign src2_mag     = (is_signed_op && bus.in_src2[WIDTH-1]) ? -bus.in_src2 : bus.in_src2;

  // Latched operands are held for MUL_STAGES cycles, so this product is a
  // multicycle path that synthesis may retime into the available stages.
  assign product = {{(WIDTH-1){mul_a[WIDTH]}}, mul_a} * {{(WIDTH-1){mul_b[WIDTH]}}, mul_b};

  // One restoring step: a set top bit in the difference is a borrow.
  assign div_shift = {div_rem, div_quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, div_dsr};
  assign quo_fixed = div_neg_q ? -div_quo : div_quo;
  assign rem_fixed = div_neg_r ? -div_rem : div_rem;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    hi_next    = hi_q;
    lo_next    = lo_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (bus.in_op)
            OP_MUL, OP_MULU: state_next = MUL;
            OP_DIV, OP_DIVU: state_next = DIV;
            OP_MTHI: begin
              wr_hi   = 1'b1;
              hi_next = bus.in_src1;
            end
            OP_MTLO: begin
              wr_lo   = 1'b1;
              lo_next = bus.in_src1;
            end
            default: state_next = IDLE;
          endcase
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = IDLE;
          wr_hi      = 1'b1;
          wr_lo      = 1'b1;
          hi_next    = product[2*WIDTH-1:WIDTH];
          lo_next    = product[WIDTH-1:0];
        end
      end
      DIV: begin
        if (bus.flush)        state_next = IDLE;
        else if (cnt == '0)   state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        if (!bus.flush) begin
          wr_hi   = 1'b1;
          wr_lo   = 1'b1;
          hi_next = div_zero ? div_src1 : rem_fixed;
          lo_next = div_zero ? '1       : quo_fixed;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= wr_hi || wr_lo;
      if (wr_hi) hi_q <= hi_next;
      if (wr_lo) lo_q <= lo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= is_div_op ? CNT_W'(WIDTH-1) : CNT_W'(MUL_STAGES-1);
    end else if ((state == MUL || state == DIV) && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // NOTE: operand and iteration registers carry no reset; they are always
  // reloaded on accept before being used, and the FSM ignores them otherwise.
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_a     <= {is_signed_op & bus.in_src1[WIDTH-1], bus.in_src1};
      mul_b     <= {is_signed_op & bus.in_src2[WIDTH-1], bus.in_src2};
      div_rem   <= '0;
      div_quo   <= src1_mag;
      div_dsr   <= src2_mag;
      div_src1  <= bus.in_src1;
      div_neg_q <= is_signed_op & (bus.in_src1[WIDTH-1] ^ bus.in_src2[WIDTH-1]);
      div_neg_r <= is_signed_op & bus.in_src1[WIDTH-1];
      div_zero  <= (bus.in_src2 == '0);
    end else if (state == DIV) begin
      if (!div_diff[WIDTH]) begin
        div_rem <= div_diff[WIDTH-1:0];
        div_quo <= {div_quo[WIDTH-2:0], 1'b1};
      end else begin
        div_rem <= div_shift[WIDTH-1:0];
        div_quo <= {div_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, attached beside the execute-stage ALU.
- Replaces the previous arrangement, which used a combinational multiplier and an external divider IP driven by ad-hoc valid flags.
- Supports signed and unsigned multiply and divide, plus MTHI/MTLO writes.
- Adds a valid/ready handshake, a configurable multiply pipeline depth, an in-house radix-2 iterative divider, defined divide-by-zero behaviour, and flush/cancel.

Parameters:
- WIDTH, 32: operand width; HI/LO are each WIDTH bits.
- MUL_STAGES, 2: multiply latency in cycles, from accept to HI/LO write; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  3  opcode: 0 MUL, 1 MULU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- in_src1  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- in_src2  in  WIDTH  multiplier or divisor.
- flush  in  1  cancel the in-flight operation (exception or branch squash).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO were updated on the previous edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (resetn=0 at an edge):
  - state=IDLE, hi=0, lo=0, done=0, busy=0, in_ready=1.
  - Reset mid-operation discards all internal state.
- Accept condition: in_valid && in_ready && !flush. in_ready = (state==IDLE). Operands and op are latched at accept; the inputs are don't-care afterwards.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on accepting MUL/MULU.
  - IDLE -> DIV on accepting DIV/DIVU.
  - MTHI/MTLO stay in IDLE: the target register is written on the accept edge, done=1 in the next cycle, and the unit remains ready.
  - Reserved opcodes: accepted, no register change, no done.
- MUL:
  - The full 2*WIDTH product is computed in MUL_STAGES cycles.
  - Signed for MUL: operands sign-extended to WIDTH+1. Unsigned for MULU: zero-extended.
  - {hi,lo} are written on the MUL_STAGES-th edge after accept; state returns to IDLE on that same edge; done=1 in the following cycle.
- DIV:
  - Restoring radix-2, one quotient bit per cycle, WIDTH iterations, on operand magnitudes.
  - DIV converts operands to magnitude with two's-complement negate; DIVU uses them as-is.
  - After the WIDTH iterations, the unit enters FIX for one cycle to apply the sign correction.
  - Quotient is negated iff the operand signs differ (DIV only). Remainder takes the sign of the dividend.
  - hi=remainder and lo=quotient are written on the FIX->IDLE edge, which is WIDTH+1 edges after accept; done follows.
  - Most-negative / -1 (DIV): lo=most-negative, hi=0 (wraps; no trap).
  - Divisor 0 (DIV or DIVU): the unit still takes the full latency; lo = all ones, hi = in_src1 unchanged.
- busy = (state != IDLE).
- done is asserted only for completions; it is never asserted together with flush-cancelled ops.
- Flush:
  - If flush=1 while busy, state goes to IDLE on that edge, hi/lo are unchanged, and no done is produced.
  - A flush on the same edge as the scheduled HI/LO write wins: no write.
  - Flush with in_valid in IDLE: the request is not accepted.
  - Flush does not cancel an MTHI/MTLO write already performed.
- Back-to-back: a new op can be accepted in the same cycle that done is high, because state is already IDLE. HI/LO reads during busy return the old values; the consumer stalls on busy.

Test Plan:
- MUL 0xFFFFFFFE * 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done exactly MUL_STAGES+1 cycles after accept.
- MULU on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done at cycle WIDTH+2 after accept; DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234.
- Start DIV, assert flush at iteration 10 -> in_ready=1 next cycle, hi/lo unchanged, no done. Then MTHI 0xA5A5A5A5 -> hi updated, done one cycle later.
- Assert resetn=0 mid-DIV -> next cycle hi=lo=0, busy=0, done=0. Then MUL 3*4 with WIDTH=8, MUL_STAGES=1 -> lo=0x0C, hi=0 after 1 cycle.
